// File: rtl/sym_gen_if.sv
// Control and symbol-output bundle for sym_gen.
// The master is the game controller; sym_gen itself takes the slave side.
interface sym_gen_if;
  logic [31:0] symGenMax;
  logic        genSym;
  logic        generated;
  logic        special;
  logic [7:0]  generatedSym;

  modport master (
    output symGenMax,
    output genSym,
    input  generated,
    input  special,
    input  generatedSym
  );

  modport slave (
    input  symGenMax,
    input  genSym,
    output generated,
    output special,
    output generatedSym
  );
endinterface

// File: rtl/sym_gen.sv
// Periodic pseudo-random ASCII symbol generator: a free-running 16-bit LFSR
// picks a symbol once every symGenMax cycles while genSym is high.
module sym_gen #(
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter logic [7:0]  SPECIAL_SYM = 8'h2A
) (
  input  logic     Clk100M,
  input  logic     Rst_n,
  sym_gen_if.slave bus
);

  logic [15:0] lfsr_q, lfsr_d;
  logic [31:0] cnt_q, cnt_d;
  logic        gen_q, gen_d;
  logic        special_q, special_d;
  logic [7:0]  sym_q, sym_d;
  logic [31:0] eff_max;
  logic [7:0]  table_sym;

  function automatic logic [7:0] sym_lookup(input logic [3:0] idx);
    logic [7:0] s;
    if (idx < 4'd10) begin
      s = 8'h30 + {4'h0, idx};
    end else if (idx < 4'd15) begin
      s = 8'h41 + {4'h0, idx} - 8'd10;
    end else begin
      s = 8'h2A;
    end
    return s;
  endfunction

  // A period of 0 would never terminate; treat it as every cycle.
  assign eff_max   = (bus.symGenMax == 32'd0) ? 32'd1 : bus.symGenMax;
  assign table_sym = sym_lookup(lfsr_q[3:0]);

  always_comb begin
    lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    cnt_d     = cnt_q;
    gen_d     = 1'b0;
    special_d = special_q;
    sym_d     = sym_q;
    if (!bus.genSym) begin
      cnt_d = 32'd0;
    end else if (cnt_q >= eff_max - 32'd1) begin
      // >= so a period shrunk below the current count fires immediately.
      cnt_d     = 32'd0;
      gen_d     = 1'b1;
      sym_d     = table_sym;
      special_d = (table_sym == SPECIAL_SYM);
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      lfsr_q    <= LFSR_SEED;
      cnt_q     <= 32'd0;
      gen_q     <= 1'b0;
      special_q <= 1'b0;
      sym_q     <= 8'h00;
    end else begin
      lfsr_q    <= lfsr_d;
      cnt_q     <= cnt_d;
      gen_q     <= gen_d;
      special_q <= special_d;
      sym_q     <= sym_d;
    end
  end

  assign bus.generated    = gen_q;
  assign bus.special      = special_q;
  assign bus.generatedSym = sym_q;

endmodule

// File: tb/tb_sym_gen.sv
// Randomized and directed checks of sym_gen against a period/LFSR reference model.
module tb_sym_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   edge_n = 0;
  int   sp_seen = 0;

  // Reference model state: edges elapsed in the current period, LFSR value.
  int unsigned m_elapsed;
  logic [15:0] m_lfsr;
  logic        m_gen;
  logic        m_sp;
  logic [7:0]  m_sym;

  sym_gen_if bus ();

  sym_gen u_dut (
    .Clk100M(clk),
    .Rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  function automatic logic [7:0] ascii_of(input int unsigned n);
    if (n < 10) return 8'(48 + n);
    if (n < 15) return 8'(65 + n - 10);
    return 8'd42;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic fb;
    fb = v[15] ^ v[13] ^ v[12] ^ v[10];
    return {v[14:0], fb};
  endfunction

  function automatic bit is_legal(input logic [7:0] s);
    return (s >= 8'h30 && s <= 8'h39) || (s >= 8'h41 && s <= 8'h45) || s == 8'h2A;
  endfunction

  task automatic model_reset();
    m_elapsed = 0;
    m_lfsr    = 16'hACE1;
    m_gen     = 1'b0;
    m_sp      = 1'b0;
    m_sym     = 8'h00;
  endtask

  task automatic model_step();
    int unsigned period;
    period = (bus.symGenMax == 0) ? 1 : bus.symGenMax;
    m_gen  = 1'b0;
    if (!bus.genSym) begin
      m_elapsed = 0;
    end else begin
      m_elapsed++;
      if (m_elapsed >= period) begin
        m_elapsed = 0;
        m_gen     = 1'b1;
        m_sym     = ascii_of(int'(m_lfsr % 16));
        m_sp      = (m_sym == 8'd42);
      end
    end
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    edge_n++;
    @(negedge clk);
    check_eq(tag, {21'd0, bus.generated, bus.special, bus.generatedSym},
             {21'd0, m_gen, m_sp, m_sym});
    if (bus.generated) begin
      if (bus.special) sp_seen++;
      check_eq({tag, "_legal"}, 32'(is_legal(bus.generatedSym)), 32'd1);
    end
  endtask

  // Called at a negedge: asserts reset, checks the async clear, releases at the next negedge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq({tag, "_rst"}, {21'd0, bus.generated, bus.special, bus.generatedSym}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  initial begin
    int first;
    model_reset();
    bus.symGenMax = 32'd10;
    bus.genSym    = 1'b1;
    @(negedge clk);
    do_reset("nominal");

    // Nominal period of 10.
    for (int i = 0; i < 35; i++) begin
      tick("nominal");
      if (edge_n == 10) check_eq("nom_e10", {23'd0, bus.generated, bus.generatedSym}, 32'h138);
      if (edge_n == 20) check_eq("nom_e20", {23'd0, bus.generated, bus.generatedSym}, 32'h145);
    end

    // Every-cycle mode, then reset while the strobe is high.
    bus.symGenMax = 32'd1;
    do_reset("every1");
    for (int i = 0; i < 6; i++) begin
      tick("every1");
      if (edge_n == 1) check_eq("ev_e1", {23'd0, bus.generated, bus.generatedSym}, 32'h131);
      if (edge_n == 2) check_eq("ev_e2", {23'd0, bus.generated, bus.generatedSym}, 32'h133);
    end
    check_eq("gen_before_rst", 32'(bus.generated), 32'd1);
    bus.symGenMax = 32'd0;
    do_reset("midrun");
    for (int i = 0; i < 6; i++) begin
      tick("every0");
      if (edge_n == 1) check_eq("ev0_e1", {23'd0, bus.generated, bus.generatedSym}, 32'h131);
      if (edge_n == 2) check_eq("ev0_e2", {23'd0, bus.generated, bus.generatedSym}, 32'h133);
    end

    // Enable gating.
    bus.symGenMax = 32'd10;
    do_reset("gate");
    for (int i = 0; i < 5; i++) tick("gate_on");
    bus.genSym = 1'b0;
    for (int i = 0; i < 3; i++) tick("gate_off");
    bus.genSym = 1'b1;
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      tick("gate_re");
      if (bus.generated && first == 0) first = i;
    end
    check_eq("reenable_lat", 32'(first), 32'd10);

    // Period shrink at count 7.
    bus.symGenMax = 32'd10;
    do_reset("shrink");
    for (int i = 0; i < 7; i++) tick("shrink_pre");
    bus.symGenMax = 32'd4;
    tick("shrink");
    check_eq("shrink_fire", 32'(bus.generated), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      tick("shrink_post");
      check_eq("shrink_cadence", 32'(bus.generated), 32'((i % 4) == 0));
    end

    // Random enable/period changes.
    bus.genSym = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19, 0) == 0) bus.genSym = ~bus.genSym;
      if ($urandom_range(29, 0) == 0) bus.symGenMax = $urandom_range(12, 0);
      tick("random");
    end

    // Long every-cycle run for the special flag.
    bus.symGenMax = 32'd1;
    bus.genSym    = 1'b1;
    do_reset("special");
    sp_seen = 0;
    for (int i = 0; i < 70000; i++) tick("special");
    check_eq("special_seen", 32'(sp_seen > 0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sym_gen.md
# sym_gen

Periodic pseudo-random symbol generator for the SymCounter game datapath. While the game period is active (`genSym` high), it emits one new 8-bit ASCII symbol every `symGenMax` clock cycles. Each new symbol comes with a one-cycle `generated` strobe and a `special` flag marking the bonus symbol. Downstream display and scoring logic consume `generatedSym` on the strobe.

## Interface
Parameters:
- `LFSR_SEED`, default 16'hACE1: LFSR value loaded at reset; must be non-zero.
- `SPECIAL_SYM`, default 8'h2A ('*'): symbol code that asserts `special`.

Ports:
- `Clk100M`  in  1  100 MHz system clock; all state on the rising edge.
- `Rst_n`  in  1  reset, asynchronous, active-low.
- `symGenMax`  in  32  generation period in clock cycles; 0 is treated as 1.
- `genSym`  in  1  game-period enable; level-sensitive.
- `generated`  out  1  one-cycle strobe: new symbol valid this cycle.
- `special`  out  1  high when `generatedSym == SPECIAL_SYM`.
- `generatedSym`  out  8  current symbol (ASCII); held between strobes.

## Operation
- **LFSR:** 16-bit Fibonacci, free-running every clock, independent of `genSym`.
  - Update: `lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}`.
- **Symbol table:** index is `lfsr[3:0]`, the pre-edge value.
  - 0-9 map to '0'-'9' (0x30-0x39).
  - 10-14 map to 'A'-'E' (0x41-0x45).
  - 15 maps to '*' (0x2A, special).
- **Period counter:** 32-bit `cnt`; effective max `M = (symGenMax==0) ? 1 : symGenMax`.
- **genSym = 1:**
  - If `cnt >= M-1`: `cnt <= 0`, `generatedSym <= table[lfsr[3:0]]`, `special <=` (that symbol == SPECIAL_SYM), `generated <= 1`.
  - Otherwise: `cnt <= cnt+1`, `generated <= 0`.
- **genSym = 0:** `cnt <= 0`, `generated <= 0`; `generatedSym` and `special` hold.
- The `>=` compare means that lowering `symGenMax` below the current count fires on the next edge. The counter never runs away.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Timing
- **Reset (async assert, synchronous deassert by the system):**
  - `generated = 0`, `special = 0`, `generatedSym = 8'h00`.
  - `cnt = 0`, `lfsr = LFSR_SEED`.
- **Strobe cadence:** with `genSym` high from reset release, `generated` is high after edges M, 2M, 3M, … for exactly one cycle each.
  - Edge numbering: edge 1 is the first rising edge after `Rst_n` rises.
- **M = 1:** `generated` stays high continuously, with a new symbol every cycle.
- **Latency:** the symbol and `special` update on the same edge that raises `generated`.
- **genSym rise:** the first strobe occurs M edges after the first edge that samples `genSym=1`.
- **genSym fall:** `generated` is low from the next edge onward. A partially counted period is discarded.
- **genSym and terminal count on the same edge:** `genSym=0` wins. No strobe, `cnt` clears.
- **Reset mid-operation:** all state returns to reset values immediately. The LFSR sequence restarts from the seed.
- **LFSR lock-up:** the LFSR never reaches 0 from a non-zero seed, so no lock-up guard is required.

## Test plan
- **Reset values:** assert `Rst_n=0` mid-run with `generated` high -> outputs immediately 0/0/0x00. After release, the first symbol matches the seed sequence again.
- **Nominal run:** `symGenMax=10`, `genSym=1` from reset release.
  - `generated` pulses one cycle after edges 10, 20, 30.
  - `generatedSym` = 0x38 ('8') after edge 10 and 0x45 ('E') after edge 20; `special = 0` for both.
- **Every-cycle mode:** `symGenMax=1`, `genSym=1` -> `generated` constantly high; `generatedSym` = 0x31 after edge 1, 0x33 after edge 2.
  - `symGenMax=0` gives an identical trace.
- **Enable gating:** `symGenMax=10`; drop `genSym` after 5 edges for 3 cycles, then raise it.
  - No strobe while low; `generatedSym` holds.
  - The next strobe arrives 10 edges after re-enable.
- **Period shrink:** at count 7 with `symGenMax=10`, change `symGenMax` to 4 -> strobe on the next edge, then every 4 edges.
- **Special flag:** `symGenMax=1` for 70000 cycles -> `special` is high exactly when `generatedSym==0x2A` and is observed at least once. No symbol falls outside the 16-entry table.
